// File: rtl/mant_div.sv
// Unsigned 48/24 mantissa divider: restoring radix-2, one quotient bit per cycle.
// Divide-by-zero and quotient-overflow cases finish immediately with saturated results.
module mant_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [47:0] dividend,
    input  logic [23:0] divisor,
    output logic [23:0] quotient,
    output logic [23:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        dbz
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] prem_q, prem_d;
    // Low dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [23:0] low_q, low_d;
    logic [23:0] dvsr_q, dvsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] quot_q, quot_d;
    logic [23:0] rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        dbz_q, dbz_d;

    logic [25:0] shifted;
    logic [25:0] diff;
    logic        stepFits;
    logic [24:0] stepPrem;
    logic [23:0] stepLow;
    logic        accept;
    logic        isDbz;
    logic        isOvf;

    always_comb begin
        shifted  = {prem_q, low_q[23]};
        diff     = shifted - {2'b00, dvsr_q};
        stepFits = ~diff[25];
        stepPrem = stepFits ? diff[24:0] : shifted[24:0];
        stepLow  = {low_q[22:0], stepFits};
        accept   = start && (state_q != CALC);
        isDbz    = (divisor == 24'h0);
        isOvf    = (dividend[47:24] >= divisor);
    end

    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        low_d   = low_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        case (state_q)
            CALC: begin
                prem_d = stepPrem;
                low_d  = stepLow;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    state_d = DONE;
                    quot_d  = stepLow;
                    rem_d   = stepPrem[23:0];
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    // Divide-by-zero is tested first so it wins over overflow.
                    if (isDbz) begin
                        state_d = DONE;
                        quot_d  = 24'hFFFFFF;
                        rem_d   = dividend[23:0];
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b1;
                    end else if (isOvf) begin
                        state_d = DONE;
                        quot_d  = 24'hFFFFFF;
                        rem_d   = 24'h0;
                        ovf_d   = 1'b1;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = CALC;
                        prem_d  = {1'b0, dividend[47:24]};
                        low_d   = dividend[23:0];
                        dvsr_d  = divisor;
                        cnt_d   = 5'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prem_q  <= 25'h0;
            low_q   <= 24'h0;
            dvsr_q  <= 24'h0;
            cnt_q   <= 5'd0;
            quot_q  <= 24'h0;
            rem_q   <= 24'h0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            low_q   <= low_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;
    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mant_div.sv
// Scoreboard bench for mant_div: directed divisions with hand-computed results,
// checked by a monitor that pops one expectation per done pulse.
module tb_mant_div;

    typedef struct {
        logic [23:0] q;
        logic [23:0] r;
        logic        ovf;
        logic        dbz;
        int          lat;
        int          busyN;
        int          acceptCyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [47:0] dividend;
    logic [23:0] divisor;
    logic [23:0] quotient;
    logic [23:0] remainder;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        dbz;

    int          cyc = 0;
    int          nChecks = 0;
    int          nFail = 0;
    int          busyCnt = 0;
    logic [49:0] lastRes = '0;
    exp_t        sb[$];
    exp_t        mon;

    mant_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one request from a negedge; the expectation is queued once the accepting edge has passed.
    task automatic applyStimulus(input logic [47:0] dvd, input logic [23:0] dvs,
                                 input logic [23:0] eq, input logic [23:0] er,
                                 input logic eo, input logic ez, input int lat, input int busyN);
        exp_t e;
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        e.q         = eq;
        e.r         = er;
        e.ovf       = eo;
        e.dbz       = ez;
        e.lat       = lat;
        e.busyN     = busyN;
        e.acceptCyc = cyc;
        sb.push_back(e);
        start    = 1'b0;
        dividend = ~dvd;
        divisor  = ~dvs;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("timeout_pending", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: results, latency and busy length at each done; held outputs while busy.
    always @(negedge clk) begin
        if (!rst_n) begin
            busyCnt = 0;
            lastRes = '0;
            sb.delete();
        end else begin
            if (busy) begin
                busyCnt++;
                checkOutput("hold_during_calc", 64'({quotient, remainder, ovf, dbz}), 64'(lastRes));
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_done", 64'd1, 64'd0);
                end else begin
                    mon = sb.pop_front();
                    checkOutput("quotient", 64'(quotient), 64'(mon.q));
                    checkOutput("remainder", 64'(remainder), 64'(mon.r));
                    checkOutput("ovf", 64'(ovf), 64'(mon.ovf));
                    checkOutput("dbz", 64'(dbz), 64'(mon.dbz));
                    checkOutput("latency", 64'(cyc - mon.acceptCyc + 1), 64'(mon.lat));
                    checkOutput("busy_cycles", 64'(busyCnt), 64'(mon.busyN));
                    lastRes = {mon.q, mon.r, mon.ovf, mon.dbz};
                end
                busyCnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 48'h0;
        divisor  = 24'h0;
        #12;
        checkOutput("reset_state", 64'({busy, done, ovf, dbz, quotient, remainder}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x123456 * 0xABCD + 0x42 divided back by 0xABCD
        applyStimulus(48'h123456 * 48'h00ABCD + 48'h42, 24'h00ABCD, 24'h123456, 24'h000042, 1'b0, 1'b0, 25, 24);
        waitIdle();
        applyStimulus(48'hFFFFFE000001, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 1'b0, 1'b0, 25, 24);
        waitIdle();
        applyStimulus(48'h000000FFFFFF, 24'h000001, 24'hFFFFFF, 24'h0, 1'b0, 1'b0, 25, 24);
        waitIdle();

        // Special cases finish one edge after acceptance
        applyStimulus(48'hFFFFFF000000, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 1'b1, 1'b0, 1, 0);
        waitIdle();
        applyStimulus(48'h000001000000, 24'h000001, 24'hFFFFFF, 24'h0, 1'b1, 1'b0, 1, 0);
        waitIdle();
        applyStimulus(48'h000000000123, 24'h000000, 24'hFFFFFF, 24'h000123, 1'b0, 1'b1, 1, 0);
        waitIdle();
        applyStimulus(48'hFFFFFFFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1, 0);
        waitIdle();

        // A start pulse mid-calculation must be ignored
        applyStimulus(48'd1000, 24'd3, 24'd333, 24'd1, 1'b0, 1'b0, 25, 24);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 48'd5;
        divisor  = 24'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();

        // Back-to-back: second start in the done cycle of the first
        applyStimulus(48'd1000000, 24'd999, 24'd1001, 24'd1, 1'b0, 1'b0, 25, 24);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        checkOutput("b2b_first_done", 64'(done), 64'd1);
        applyStimulus(48'd100, 24'd7, 24'd14, 24'd2, 1'b0, 1'b0, 25, 24);
        waitIdle();

        // Reset in the middle of a calculation abandons it without a done pulse
        applyStimulus(48'd1000, 24'd3, 24'd333, 24'd1, 1'b0, 1'b0, 25, 24);
        waitIdle();
        applyStimulus(48'd1000000, 24'd999, 24'd1001, 24'd1, 1'b0, 1'b0, 25, 24);
        repeat (11) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", 64'({busy, done, ovf, dbz, quotient, remainder}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        applyStimulus(48'd100, 24'd7, 24'd14, 24'd2, 1'b0, 1'b0, 25, 24);
        waitIdle();

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/mant_div.md
MANT_DIV -- requirements
Module: mant_div

Interface
REQ-001 SHALL have no parameters: dividend width is fixed at 48, divisor/quotient/remainder widths at 24, all unsigned.
REQ-002 SHALL provide these ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- dividend  input  48  numerator, e.g. a 48-bit mantissa product.
- divisor  input  24  denominator.
- quotient  output  24  result.
- remainder  output  24  result.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle result-valid pulse.
- ovf  output  1  quotient-overflow flag.
- dbz  output  1  divide-by-zero flag.

Function
REQ-003 SHALL use states IDLE, CALC and DONE.
- IDLE -> CALC on an accepted normal start.
- IDLE -> DONE on an accepted start that is a special case (REQ-010, REQ-011).
- CALC -> DONE after iteration 24.
- DONE -> IDLE, or DONE -> CALC/DONE on a same-cycle start.
REQ-004 SHALL accept start only in IDLE or DONE; start in CALC SHALL be ignored with no effect on the operation in flight.
REQ-005 SHALL capture dividend and divisor at the accepting edge; inputs SHALL be don't-care afterwards.
REQ-006 SHALL assert busy=1 exactly while in CALC.
REQ-007 SHALL use a restoring radix-2 algorithm, one quotient bit per cycle, MSB first:
- 25-bit partial remainder, initialised to dividend[47:24].
- Each step shifts in the next dividend bit, from bit 23 down to bit 0.
- Each step subtracts the divisor if the result is non-negative and sets the quotient bit.
REQ-008 SHALL have fixed latency for a normal operation: start accepted at edge N -> done high during the cycle following edge N+24.
REQ-009 SHALL produce, on a normal operation, quotient = floor(dividend/divisor) and remainder = dividend mod divisor, both exact in 24 bits; ovf=0 and dbz=0.
REQ-010 SHALL treat divisor=0 as divide-by-zero: done at edge N+1, quotient=24'hFFFFFF, remainder=dividend[23:0], dbz=1, ovf=0.
REQ-011 SHALL treat divisor!=0 with dividend[47:24] >= divisor as overflow: done at edge N+1, quotient=24'hFFFFFF, remainder=24'h0, ovf=1, dbz=0.
REQ-012 SHALL give divide-by-zero priority over overflow.
REQ-013 SHALL keep done high for exactly one cycle per accepted start.
REQ-014 SHALL keep quotient, remainder, ovf and dbz stable from the done cycle until the next done; they SHALL not change during CALC.
REQ-015 SHALL accept a start arriving in the DONE cycle back-to-back, with the same latency as REQ-008, REQ-010 and REQ-011.
REQ-016 SHALL not expose intermediate iteration values on any output.

Reset
REQ-017 SHALL, while rst_n=0 (asynchronous, regardless of clk):
- set state=IDLE;
- set busy, done, ovf and dbz to 0;
- set quotient and remainder to 24'h0;
- clear the iteration counter and all internal registers.
REQ-018 SHALL, on reset during CALC, abandon the operation with no done pulse; the first edge after release with start=1 SHALL begin a fresh operation.

Verification
REQ-019 Normal: dividend = 24'h123456*24'h00ABCD + 24'h000042, divisor=24'h00ABCD -> done exactly 25 cycles after the start edge, quotient=24'h123456, remainder=24'h000042, ovf=0, dbz=0, busy high for 24 cycles.
REQ-020 Maximum legal: dividend=48'hFFFFFE000001, divisor=24'hFFFFFF -> quotient=24'hFFFFFF, remainder=0, ovf=0.
REQ-021 Special cases, each with done 1 cycle after start:
- dividend=48'hFFFFFF000000, divisor=24'hFFFFFF -> ovf=1, quotient=24'hFFFFFF, remainder=0.
- divisor=0, dividend=48'h000000000123 -> dbz=1, ovf=0, quotient=24'hFFFFFF, remainder=24'h000123.
REQ-022 Start ignored: pulse start with new operands at cycle 10 of a busy operation -> the in-flight result is unchanged, with a single done pulse.
REQ-023 Back-to-back: assert start in the done cycle with dividend=48'd100, divisor=24'd7 -> the first result holds until the second done, 25 cycles later, quotient=14, remainder=2.
REQ-024 Reset mid-CALC: drop rst_n at cycle 12 -> outputs go to 0 immediately and no done occurs; a restart after release gives a correct result.
